// File: rtl/packet_inject_scheduler_if.sv
// Injection channel between the scheduler and a NoC router port.
//   inj_valid  : packet offered on inj_router/inj_packet
//   inj_ready  : target router accepts the offered packet
//   inj_router : destination router index
//   inj_packet : {valid flag, payload}
//   dlv_valid  : single-cycle delivery report from the network
// master = scheduler side, slave = network side.
interface packet_inject_scheduler_if #(
   parameter int unsigned BIT = 5,
   parameter int unsigned N2  = 13
);
   logic           inj_valid;
   logic           inj_ready;
   logic [BIT-1:0] inj_router;
   logic [N2-1:0]  inj_packet;
   logic           dlv_valid;

   modport master (
      output inj_valid,
      output inj_router,
      output inj_packet,
      input  inj_ready,
      input  dlv_valid
   );

   modport slave (
      input  inj_valid,
      input  inj_router,
      input  inj_packet,
      output inj_ready,
      output dlv_valid
   );
endinterface

// File: rtl/packet_inject_scheduler.sv
// Board-level injection controller for the NoC test harness. Keys edit a destination router and a
// payload; key_send queues the pair in a small FIFO. Queued requests are issued one at a time over
// a valid/ready handshake, then the block waits for a delivery report or a timeout.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   sw_sel_data/router       : choose which field(s) key_inc/key_dec edit
//   key_inc/key_dec/key_send : synchronised key levels, acted on at rising edge
//   inj                      : injection channel (master modport)
//   cur_data, cur_router     : fields currently being edited
//   fifo_full, overflow      : FIFO full, sticky dropped-send flag
//   busy                     : FSM active or requests pending
//   delivered_cnt/timeout_cnt: saturating outcome counters
module packet_inject_scheduler #(
   parameter int unsigned N_ROUTERS  = 25,
   parameter int unsigned BIT        = 5,
   parameter int unsigned N2         = 13,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sw_sel_data,
   input  logic                          sw_sel_router,
   input  logic                          key_inc,
   input  logic                          key_dec,
   input  logic                          key_send,
   packet_inject_scheduler_if.master     inj,
   output logic [N2-2:0]                 cur_data,
   output logic [BIT-1:0]                cur_router,
   output logic                          fifo_full,
   output logic                          overflow,
   output logic                          busy,
   output logic [7:0]                    delivered_cnt,
   output logic [7:0]                    timeout_cnt
);

   localparam int unsigned PW      = N2 - 1;
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned TMR_W   = $clog2(TIMEOUT + 1);
   localparam int unsigned ENTRY_W = BIT + PW;

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   // key history and edge detection
   logic inc_q, dec_q, send_q;
   logic inc_edge, dec_edge, send_edge;
   logic step_up, step_dn;

   // edited fields
   logic [PW-1:0]  cur_data_q, cur_data_d;
   logic [BIT-1:0] cur_router_q, cur_router_d;

   // request FIFO
   logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               full, empty, push, pop;
   logic [ENTRY_W-1:0] head;

   // FSM and issue registers
   state_e         state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [BIT-1:0] issue_router_q;
   logic [PW-1:0]  issue_data_q;
   logic           dlv_inc, tmo_inc;
   logic           overflow_q;
   logic [7:0]     dlv_cnt_q, tmo_cnt_q;

   assign inc_edge  = key_inc & ~inc_q;
   assign dec_edge  = key_dec & ~dec_q;
   assign send_edge = key_send & ~send_q;
   // simultaneous inc and dec edges cancel
   assign step_up   = inc_edge & ~dec_edge;
   assign step_dn   = dec_edge & ~inc_edge;

   always_comb begin
      cur_data_d   = cur_data_q;
      cur_router_d = cur_router_q;
      if (sw_sel_data) begin
         if (step_up) cur_data_d = cur_data_q + 1'b1;
         else if (step_dn) cur_data_d = cur_data_q - 1'b1;
      end
      if (sw_sel_router) begin
         if (step_up) begin
            cur_router_d = (cur_router_q == BIT'(N_ROUTERS - 1)) ? '0 : cur_router_q + 1'b1;
         end else if (step_dn) begin
            cur_router_d = (cur_router_q == '0) ? BIT'(N_ROUTERS - 1) : cur_router_q - 1'b1;
         end
      end
   end

   // Fullness is judged at the start of the cycle, so a pop in the same cycle does not make room.
   assign full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign push  = send_edge & ~full;
   assign pop   = (state_q == StIdle) & ~empty;
   assign head  = fifo_mem[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      dlv_inc = 1'b0;
      tmo_inc = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty) state_d = StIssue;
         end
         StIssue: begin
            if (inj.inj_ready) begin
               state_d = StWait;
               timer_d = '0;
            end
         end
         StWait: begin
            // a delivery report wins over a coincident timeout
            if (inj.dlv_valid) begin
               dlv_inc = 1'b1;
               state_d = StIdle;
            end else if (timer_q == TMR_W'(TIMEOUT)) begin
               tmo_inc = 1'b1;
               state_d = StIdle;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inc_q        <= 1'b0;
         dec_q        <= 1'b0;
         send_q       <= 1'b0;
         cur_data_q   <= '0;
         cur_router_q <= '0;
      end else begin
         inc_q        <= key_inc;
         dec_q        <= key_dec;
         send_q       <= key_send;
         cur_data_q   <= cur_data_d;
         cur_router_q <= cur_router_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr_q] <= {cur_router_q, cur_data_q};
            wr_ptr_q           <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         if (send_edge && full) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         timer_q        <= '0;
         issue_router_q <= '0;
         issue_data_q   <= '0;
         dlv_cnt_q      <= '0;
         tmo_cnt_q      <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         if (pop) begin
            issue_router_q <= head[ENTRY_W-1:PW];
            issue_data_q   <= head[PW-1:0];
         end
         if (dlv_inc && dlv_cnt_q != 8'hFF) dlv_cnt_q <= dlv_cnt_q + 1'b1;
         if (tmo_inc && tmo_cnt_q != 8'hFF) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end

   assign inj.inj_valid  = (state_q == StIssue);
   assign inj.inj_router = inj.inj_valid ? issue_router_q : '0;
   assign inj.inj_packet = inj.inj_valid ? {1'b1, issue_data_q} : '0;

   assign cur_data      = cur_data_q;
   assign cur_router    = cur_router_q;
   assign fifo_full     = full;
   assign overflow      = overflow_q;
   assign busy          = (state_q != StIdle) | ~empty;
   assign delivered_cnt = dlv_cnt_q;
   assign timeout_cnt   = tmo_cnt_q;

endmodule

// File: tb/tb_packet_inject_scheduler.sv
module tb_packet_inject_scheduler;

   localparam int NR = 25;
   localparam int DMOD = 4096;
   localparam int TMO = 255;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sw_sel_data = 1'b0, sw_sel_router = 1'b0;
   logic key_inc = 1'b0, key_dec = 1'b0, key_send = 1'b0;
   logic [11:0] cur_data;
   logic [4:0]  cur_router;
   logic        fifo_full, overflow, busy;
   logic [7:0]  delivered_cnt, timeout_cnt;

   packet_inject_scheduler_if #(.BIT(5), .N2(13)) inj ();

   packet_inject_scheduler dut (
      .clk           (clk),
      .rst           (rst),
      .sw_sel_data   (sw_sel_data),
      .sw_sel_router (sw_sel_router),
      .key_inc       (key_inc),
      .key_dec       (key_dec),
      .key_send      (key_send),
      .inj           (inj),
      .cur_data      (cur_data),
      .cur_router    (cur_router),
      .fifo_full     (fifo_full),
      .overflow      (overflow),
      .busy          (busy),
      .delivered_cnt (delivered_cnt),
      .timeout_cnt   (timeout_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference model: pending requests in a queue, the in-flight packet as a phase plus the
   // absolute cycle at which it would be declared lost.
   typedef struct { int r; int d; } req_t;
   req_t m_q[$];
   int  m_data, m_router, m_phase, m_r, m_d, m_deadline, m_cyc, m_dlv, m_tmo;
   bit  m_ovf, p_inc, p_dec, p_snd;

   task automatic model_reset();
      m_q.delete();
      m_data = 0; m_router = 0; m_phase = 0; m_r = 0; m_d = 0;
      m_deadline = 0; m_cyc = 0; m_dlv = 0; m_tmo = 0;
      m_ovf = 0; p_inc = 0; p_dec = 0; p_snd = 0;
   endtask

   task automatic model_step(input bit sd, sr, inc, dec, snd, rdy, dlv);
      bit ei, ed, es, take;
      req_t h;
      int delta;
      ei = inc && !p_inc;
      ed = dec && !p_dec;
      es = snd && !p_snd;
      take = (m_phase == 0) && (m_q.size() > 0);
      if (es) begin
         if (m_q.size() < DEPTH) m_q.push_back('{r: m_router, d: m_data});
         else m_ovf = 1;
      end
      if (take) h = m_q.pop_front();
      if (ei != ed) begin
         delta = ei ? 1 : -1;
         if (sd) m_data = (m_data + delta + DMOD) % DMOD;
         if (sr) m_router = (m_router + delta + NR) % NR;
      end
      case (m_phase)
         0: if (take) begin m_r = h.r; m_d = h.d; m_phase = 1; end
         1: if (rdy) begin m_phase = 2; m_deadline = m_cyc + 1 + TMO; end
         default: begin
            if (dlv) begin
               if (m_dlv < 255) m_dlv++;
               m_phase = 0;
            end else if (m_cyc == m_deadline) begin
               if (m_tmo < 255) m_tmo++;
               m_phase = 0;
            end
         end
      endcase
      p_inc = inc; p_dec = dec; p_snd = snd;
      m_cyc++;
   endtask

   task automatic compare_all();
      check_eq("inj_valid", inj.inj_valid, m_phase == 1);
      check_eq("inj_packet", inj.inj_packet, (m_phase == 1) ? (32'h1000 | m_d) : 0);
      if (m_phase == 1) check_eq("inj_router", inj.inj_router, m_r);
      check_eq("cur_data", cur_data, m_data);
      check_eq("cur_router", cur_router, m_router);
      check_eq("fifo_full", fifo_full, m_q.size() == DEPTH);
      check_eq("overflow", overflow, m_ovf);
      check_eq("busy", busy, (m_phase != 0) || (m_q.size() != 0));
      check_eq("delivered_cnt", delivered_cnt, m_dlv);
      check_eq("timeout_cnt", timeout_cnt, m_tmo);
   endtask

   // Compare the current cycle, drive the inputs sampled at the coming posedge, advance model.
   task automatic step(input bit sd, sr, inc, dec, snd, rdy, dlv);
      compare_all();
      sw_sel_data = sd; sw_sel_router = sr;
      key_inc = inc; key_dec = dec; key_send = snd;
      inj.inj_ready = rdy; inj.dlv_valid = dlv;
      model_step(sd, sr, inc, dec, snd, rdy, dlv);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sw_sel_data = 0; sw_sel_router = 0; key_inc = 0; key_dec = 0; key_send = 0;
      inj.inj_ready = 0; inj.dlv_valid = 0;
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_pkt[3];
      int idx, lc, hs;
      int dlv_pct;
      inj.inj_ready = 0; inj.dlv_valid = 0;
      @(negedge clk);
      do_reset();

      // 1: router 3, payload 0, latency t -> t+2
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, 0, 0, 0, 0);
         step(0, 1, 0, 0, 0, 0, 0);
      end
      check_eq("t1_cur_router", cur_router, 3);
      step(0, 0, 0, 0, 1, 0, 0);
      check_eq("t1_valid_t1", inj.inj_valid, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      check_eq("t1_valid_t2", inj.inj_valid, 1);
      check_eq("t1_router", inj.inj_router, 3);
      check_eq("t1_packet", inj.inj_packet, 32'h1000);
      step(0, 0, 0, 0, 0, 1, 0);
      check_eq("t1_valid_drop", inj.inj_valid, 0);
      idle(3);
      step(0, 0, 0, 0, 0, 0, 1);
      check_eq("t1_delivered", delivered_cnt, 1);

      // 2: wraps and cancelling edges
      do_reset();
      step(0, 1, 0, 1, 0, 0, 0);
      check_eq("t2_router_wrap_dn", cur_router, 24);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0);
      check_eq("t2_router_wrap_up", cur_router, 0);
      step(1, 0, 0, 1, 0, 0, 0);
      check_eq("t2_data_wrap_dn", cur_data, 32'hFFF);
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 0, 0, 0);
      check_eq("t2_cancel_data", cur_data, 32'hFFF);
      check_eq("t2_cancel_router", cur_router, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0);
      check_eq("t2_both_data", cur_data, 0);
      check_eq("t2_both_router", cur_router, 1);

      // 3: held send, fill, overflow
      do_reset();
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      check_eq("t3_hold_valid", inj.inj_valid, 1);
      check_eq("t3_hold_full", fifo_full, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 1, 0, 0);
         step(0, 0, 0, 0, 0, 0, 0);
      end
      check_eq("t3_full", fifo_full, 1);
      check_eq("t3_no_ovf", overflow, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      check_eq("t3_ovf", overflow, 1);

      // 4: timeout after TIMEOUT+1 wait cycles, then delivery in the final cycle
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         step(0, 0, 0, 0, 1, 0, 0);
         step(0, 0, 0, 0, 0, 0, 0);
         step(0, 0, 0, 0, 0, 1, 0);
         idle(TMO);
         check_eq("t4_still_busy", busy, 1);
         check_eq("t4_no_tmo_yet", timeout_cnt, 0);
         step(0, 0, 0, 0, 0, 0, pass == 1);
         check_eq("t4_idle", busy, 0);
         check_eq("t4_tmo", timeout_cnt, (pass == 0) ? 1 : 0);
         check_eq("t4_dlv", delivered_cnt, (pass == 1) ? 1 : 0);
      end

      // 5: three ordered issues with delivery 4 cycles after each handshake
      do_reset();
      for (int i = 0; i < 3; i++) begin
         exp_pkt[i] = 32'h1000 | i;
         step(0, 0, 0, 0, 1, 0, 0);
         step(1, 0, 1, 0, 0, 0, 0);
         step(0, 0, 0, 0, 0, 0, 0);
      end
      idx = 0; hs = -100;
      for (lc = 0; lc < 100 && delivered_cnt < 3; lc++) begin
         if (inj.inj_valid) begin
            if (idx < 3) check_eq("t5_order", inj.inj_packet, exp_pkt[idx]);
            idx++;
            hs = lc;
         end
         step(0, 0, 0, 0, 0, 1, lc == hs + 4);
      end
      check_eq("t5_issued", idx, 3);
      check_eq("t5_delivered", delivered_cnt, 3);
      // reset in the middle of an offer
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      check_eq("t5_pre_rst_valid", inj.inj_valid, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("t5_rst_valid", inj.inj_valid, 0);
      check_eq("t5_rst_packet", inj.inj_packet, 0);
      check_eq("t5_rst_busy", busy, 0);
      check_eq("t5_rst_dlv", delivered_cnt, 0);
      check_eq("t5_rst_full", fifo_full, 0);
      do_reset();

      // randomized traffic against the model; dlv-free windows force timeouts
      for (int blk = 0; blk < 6; blk++) begin
         dlv_pct = (blk % 2 == 0) ? 15 : 0;
         for (int i = 0; i < 700; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < dlv_pct);
         end
      end
      compare_all();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
